// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction prefetch buffer between the instruction ROM and
// the IF/ID register. Owns the fetch PC, fetches one word per cycle while the
// queue has room, and hands {pc, inst} pairs to decode with a valid/stall
// handshake. A redirect empties the queue and restarts fetch at the target.
//
// Optional feature: define INST_PREFETCH_BYPASS_EN to forward the ROM word
// straight to the head outputs when the queue is empty (zero fetch latency).
module inst_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rom_data_i,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        stall_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   fpc;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic fetch;
    logic head_valid;
    logic push;
    logic pop;

    // Fetch/pop decisions and head outputs; all based on the pre-edge count,
    // so a full queue being popped does not fetch until the following cycle.
    always_comb begin
        fetch      = !rst && !flush_i && (count < CNT_FULL);
        head_valid = (count != '0);
        pop        = head_valid && !stall_i && !flush_i;
        push       = fetch;
        id_valid_o = head_valid;
        id_pc_o    = 32'h0;
        id_inst_o  = 32'h0;
        if (head_valid) begin
            id_pc_o   = mem_pc[rd_ptr];
            id_inst_o = mem_inst[rd_ptr];
        end
`ifdef INST_PREFETCH_BYPASS_EN
        // Empty queue: present the word being fetched right now. If decode
        // takes it this cycle it never needs to be stored.
        if (!head_valid && fetch) begin
            id_valid_o = 1'b1;
            id_pc_o    = fpc;
            id_inst_o  = rom_data_i;
            push       = stall_i;
        end
`endif
        rom_ce_o   = fetch;
        rom_addr_o = fpc;
    end

    // Fetch PC, queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            fpc    <= {new_pc_i[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // fpc advances on every fetch, including a bypassed one that is
            // consumed without being stored.
            if (fetch) fpc    <= fpc + 32'd4;
            if (push)  wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Queue storage; push is already suppressed during reset and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= fpc;
            mem_inst[wr_ptr] <= rom_data_i;
        end
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch (default build, DEPTH=4, RESET_PC=0).
// The ROM returns address ^ 32'hA5A5_0000 so every inst is predictable.
module tb_inst_prefetch;

    localparam logic [31:0] XORK = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] rom_data;
    logic [31:0] rom_addr;
    logic        rom_ce;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int n_tests = 0;
    int n_fail  = 0;

    inst_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_data_i (rom_data),
        .rom_addr_o (rom_addr),
        .rom_ce_o   (rom_ce),
        .flush_i    (flush),
        .new_pc_i   (new_pc),
        .stall_i    (stall),
        .id_pc_o    (id_pc),
        .id_inst_o  (id_inst),
        .id_valid_o (id_valid)
    );

    assign rom_data = rom_addr ^ XORK;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, then let outputs settle before checks/input changes.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check({tag, " valid"}, 32'(id_valid), 32'd1);
        check({tag, " pc"}, id_pc, pc);
        check({tag, " inst"}, id_inst, pc ^ XORK);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        flush  = 1'b0;
        new_pc = 32'h0;
        stall  = 1'b0;

        // Reset and release, free-running stream.
        tick();
        tick();
        check("rst ce", 32'(rom_ce), 32'd0);
        check("rst valid", 32'(id_valid), 32'd0);
        check("rst pc", id_pc, 32'h0);
        check("rst inst", id_inst, 32'h0);
        check("rst addr", rom_addr, 32'h0);
        rst = 1'b0;
        #1;
        check("rel valid", 32'(id_valid), 32'd0);
        check("rel ce", 32'(rom_ce), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_head("stream", 32'(4 * k));
        end

        // Stall for 8 cycles from reset: 4 fetches then ce drops, head holds 0.
        stall = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check("stall ce", 32'(rom_ce), (i < 4) ? 32'd1 : 32'd0);
            check("stall pc", id_pc, 32'h0);
            tick();
        end
        stall = 1'b0;
        #1;
        check("full ce", 32'(rom_ce), 32'd0);
        expect_head("drain", 32'h0);
        for (int i = 1; i < 6; i++) begin
            tick();
            if (i == 1) check("resume ce", 32'(rom_ce), 32'd1);
            expect_head("drain", 32'(4 * i));
        end

        // Fill, then reset while full with stall released.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b0;
        rst   = 1'b1;
        #1;
        check("midrst ce", 32'(rom_ce), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst valid", 32'(id_valid), 32'd0);
        check("midrst addr", rom_addr, 32'h0);
        tick();
        expect_head("restart", 32'h0);
        tick();
        expect_head("restart", 32'h4);

        // Flush with 3 entries queued.
        stall = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        check("q3 pc", id_pc, 32'h0);
        flush  = 1'b1;
        new_pc = 32'h0000_0100;
        stall  = 1'b0;
        #1;
        check("flush ce", 32'(rom_ce), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl+1 valid", 32'(id_valid), 32'd0);
        check("fl+1 addr", rom_addr, 32'h100);
        check("fl+1 ce", 32'(rom_ce), 32'd1);
        tick();
        expect_head("fl+2", 32'h100);
        tick();
        expect_head("fl+3", 32'h104);

        // Misaligned target is forced to word alignment.
        flush  = 1'b1;
        new_pc = 32'h0000_0103;
        tick();
        flush = 1'b0;
        #1;
        check("mis addr0", rom_addr, 32'h100);
        tick();
        check("mis addr1", rom_addr, 32'h104);
        expect_head("mis", 32'h100);

        // Fetch address wraps past the top of memory.
        flush  = 1'b1;
        new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        #1;
        check("wrap addr", rom_addr, 32'hFFFF_FFFC);
        tick();
        expect_head("wrap0", 32'hFFFF_FFFC);
        tick();
        expect_head("wrap1", 32'h0000_0000);
        tick();
        expect_head("wrap2", 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Instruction prefetch buffer between the instruction ROM and the IF/ID pipeline register. It owns the fetch PC, drives the ROM address and chip-enable, and queues {pc, inst} pairs in a small FIFO. Instructions are delivered to the decode side with a valid/stall handshake, and the queue is flushed on a redirect (branch/jump target).

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rom_data_i  in  32  instruction word from the ROM; combinational in rom_addr_o when rom_ce_o=1.
- rom_addr_o  out  32  fetch address; equals the internal fetch PC (fpc).
- rom_ce_o  out  1  ROM enable; a fetch occurs in every cycle it is 1.
- flush_i  in  1  redirect request.
- new_pc_i  in  32  redirect target; sampled when flush_i=1.
- stall_i  in  1  downstream cannot accept this cycle.
- id_pc_o  out  32  PC of the head instruction.
- id_inst_o  out  32  head instruction word.
- id_valid_o  out  1  head is valid.

## Operation
- State:
  - fpc (32b).
  - FIFO storage of DEPTH × 64b {pc, inst}.
  - Read and write pointers, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - count (log2(DEPTH)+1 bits).
- Fetch: rom_ce_o = !rst && !flush_i && (count < DEPTH), evaluated on the pre-edge count.
  - On a fetch, {fpc, rom_data_i} is written at the write pointer and fpc <= fpc + 4.
  - fpc wraps from 32'hFFFF_FFFC to 0.
- Delivery:
  - id_valid_o = (count != 0).
  - id_pc_o and id_inst_o come from the head entry; both are 32'h0 when empty.
  - A pop occurs when id_valid_o && !stall_i.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with pop: no fetch this cycle, because ce is based on pre-pop count. count decrements, and the fetch resumes next cycle.
- Flush:
  - At the edge: count <= 0 and pointers <= 0.
  - fpc <= {new_pc_i[31:2], 2'b00}; the low 2 bits are forced to zero.
  - No fetch and no pop are counted in the flush cycle. id_valid_o still reflects pre-flush contents during that cycle, and downstream must ignore it.
- Priority: rst > flush_i > push/pop.

## Timing
- Reset (rst=1 at an edge), next cycle:
  - count=0 and pointers=0.
  - fpc=RESET_PC, so rom_addr_o=RESET_PC.
  - During rst, rom_ce_o=0.
  - id_valid_o=0, id_pc_o=0, id_inst_o=0.
- Reset mid-stream discards all queued entries with no partial output.
- Fetch-to-output latency is 1 cycle: a word fetched in cycle t is at the head in cycle t+1 if the FIFO was empty.
- Steady state with stall_i=0 is one instruction per cycle with no bubbles.
- Release of a stall on a full FIFO also gives no bubble:
  - The first pop leaves count=DEPTH-1.
  - The fetch resumes the next cycle.
  - The fetched word is at the tail before the queue drains.
- Flush in cycle t:
  - Cycle t+1: id_valid_o=0, rom_addr_o=aligned new_pc_i, rom_ce_o=1.
  - Cycle t+2: id_pc_o=new target, id_valid_o=1.
- No ROM wait states; rom_data_i must be valid in the same cycle as rom_addr_o.

## Configuration
- INST_PREFETCH_BYPASS_EN defined: when count=0 and rom_ce_o=1, the head outputs bypass the FIFO combinationally.
  - id_valid_o=1, id_pc_o=fpc, id_inst_o=rom_data_i.
  - If stall_i=0, the word is consumed and not written.
  - If stall_i=1, it is written as normal.
  - Fetch-to-output latency is 0; the flush-to-target latency becomes 1 cycle.
- Not defined: outputs are driven only from FIFO storage (registered-derived), with 1-cycle latency as above.

## Test plan
- Reset release, stall_i=0, ROM word = address XOR 32'hA5A5_0000:
  - id_valid_o is 0 in the first cycle after release.
  - Then id_pc_o = 0, 4, 8, C… on consecutive cycles with the matching inst.
- stall_i=1 for 8 cycles from reset, DEPTH=4:
  - rom_ce_o falls after 4 fetches and id_pc_o holds 0.
  - On release, pcs 0, 4, 8, C, 10, 14 appear on consecutive cycles with no gap.
- With 3 entries queued, flush_i=1 with new_pc_i=32'h0000_0100:
  - The next cycle has id_valid_o=0 and rom_addr_o=0x100.
  - The cycle after has id_pc_o=0x100; no old PC ever reappears.
- Flush with new_pc_i=32'h0000_0103: fetch addresses are 0x100, 0x104.
- Flush to 32'hFFFF_FFFC: output pcs are FFFF_FFFC, then 0000_0000, then 0000_0004.
- Assert rst for one cycle while the FIFO is full and stall_i=0:
  - The next cycle has id_valid_o=0 and rom_addr_o=RESET_PC.
  - The stream restarts from RESET_PC.
